mmio_io_bridge: RTL

//  Memory-mapped I/O bridge between the processor data-memory port and board I/O.

---
 rtl/mmio_io_bridge_if.sv | 13 +
 rtl/mmio_io_bridge.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mmio_io_bridge_if.sv
// Processor data-memory port as seen by the MMIO bridge.
// The master drives address/strobes; the slave returns read data and the range hit.
interface mmio_io_bridge_if;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        wren;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        io_hit;

  modport master (output addr, wr_data, wren, rd_en, input rd_data, io_hit);
  modport slave  (input addr, wr_data, wren, rd_en, output rd_data, io_hit);
endinterface

// File: rtl/mmio_io_bridge.sv
// MMIO bridge: synchronised (optionally debounced) inputs, writable output registers,
// sticky read-clear change flag. Define MMIO_DEBOUNCE_EN to include the debounce counter.
module mmio_io_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'd4096,
  parameter int          IN_W        = 16,
  parameter int          OUT_W       = 16,
  parameter int          NUM_OUT     = 2,
  parameter int          SYNC_STAGES = 2,
  parameter int          DB_CYCLES   = 50000
) (
  input  logic                     clock,
  input  logic                     reset,
  mmio_io_bridge_if.slave          bus,
  input  logic [IN_W-1:0]          in_raw,
  output logic [NUM_OUT*OUT_W-1:0] out_bus
);

  // Range compare is done in 33 bits so a base near 2^32 cannot wrap onto low addresses.
  localparam logic [32:0] LO_ADDR  = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_ADDR  = LO_ADDR + 33'(NUM_OUT + 1);
  localparam logic [31:0] STAT_OFS = 32'(NUM_OUT + 1);

  logic [32:0]     addr_ext;
  logic [31:0]     offset;
  logic            hit;
  logic [IN_W-1:0] sync_p [SYNC_STAGES];
  logic [IN_W-1:0] sync_q;
  logic [IN_W-1:0] stab;
  logic [IN_W-1:0] stab_nxt;
  logic            stab_chg;
  logic            flag;
  logic            stat_clr;
  logic [OUT_W-1:0] out_q [NUM_OUT];
  logic [31:0]     rd;
  logic            unused_wr;

  assign addr_ext   = {1'b0, bus.addr};
  assign hit        = (addr_ext >= LO_ADDR) && (addr_ext <= HI_ADDR);
  assign offset     = bus.addr - BASE_ADDR;
  assign bus.io_hit = hit;
  assign unused_wr  = ^bus.wr_data;

  // Stage: input synchroniser chain
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= in_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign sync_q = sync_p[SYNC_STAGES-1];

  // Stage: stable value selection
`ifdef MMIO_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    stab_nxt = stab;
    cnt_nxt  = '0;
    if (sync_q != stab) begin
      if (cnt == CNT_LAST) stab_nxt = sync_q;
      else                 cnt_nxt  = cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt_nxt;
  end
`else
  localparam int unused_db_cycles = DB_CYCLES;

  always_comb begin
    stab_nxt = sync_q;
  end
`endif

  assign stab_chg = (stab_nxt != stab);
  assign stat_clr = hit && bus.rd_en && !bus.wren && (offset == STAT_OFS);

  // A change landing with a read-clear wins, so no input edge is ever lost.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stab <= '0;
      flag <= 1'b0;
    end else begin
      stab <= stab_nxt;
      if (stab_chg)      flag <= 1'b1;
      else if (stat_clr) flag <= 1'b0;
    end
  end

  // Stage: output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
    end else if (hit && bus.wren) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (offset == 32'(k + 1)) out_q[k] <= bus.wr_data[OUT_W-1:0];
      end
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_bus[g*OUT_W +: OUT_W] = out_q[g];
  end

  always_comb begin
    rd = '0;
    if (hit) begin
      if (offset == 32'd0)           rd[IN_W-1:0] = stab;
      else if (offset == STAT_OFS)   rd[0]        = flag;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (offset == 32'(k + 1)) rd[OUT_W-1:0] = out_q[k];
      end
    end
  end

  assign bus.rd_data = rd;

endmodule
